// File: rtl/debounce_pkg.sv
// Shared types and parameter checks for the push-button debouncer array.
package debounce_pkg;

  // Per-channel debounce FSM state.
  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } deb_state_t;

  // Returns 1 when the debouncer parameter set is legal: the counter must be
  // able to hold both thresholds, the synchroniser needs at least two flops,
  // and a stable window of one sample would defeat the debounce entirely.
  function automatic bit params_ok(
    input int n_ch,
    input int cnt_w,
    input int stable_cycles,
    input int long_cycles,
    input int sync_stages
  );
    bit     ok;
    longint cnt_max;
    ok = 1'b1;
    if (cnt_w < 1 || cnt_w > 62) begin
      ok = 1'b0;
    end else begin
      cnt_max = (longint'(1) << cnt_w) - 1;
      if (n_ch < 1)                               ok = 1'b0;
      if (sync_stages < 2)                        ok = 1'b0;
      if (stable_cycles < 2)                      ok = 1'b0;
      if (longint'(stable_cycles) > cnt_max)      ok = 1'b0;
      if (long_cycles < 1)                        ok = 1'b0;
      if (longint'(long_cycles) > cnt_max)        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced push-button: synchroniser, stable-time FSM/counter and
// long-press tracking, with registered level and one-cycle event pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 10,
  parameter int LONG_CYCLES   = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic BOT,
  output logic BOTOUT,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG
);

  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;

  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             long_fired, long_fired_nxt;
  logic             botout_nxt, press_nxt, release_nxt, long_nxt;

  assign s = sync_p0[SYNC_STAGES-1];

  // Synchroniser shift chain; keeps running while EN is low so the FSM
  // resumes on a fresh view of the button.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], BOT};
    end
  end

  // State register plus registered outputs; EN low freezes state and
  // suppresses pulses while BOTOUT keeps its level.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      long_fired <= 1'b0;
      BOTOUT     <= 1'b0;
      PRESS      <= 1'b0;
      RELEASE    <= 1'b0;
      LONG       <= 1'b0;
    end else if (EN) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      long_fired <= long_fired_nxt;
      BOTOUT     <= botout_nxt;
      PRESS      <= press_nxt;
      RELEASE    <= release_nxt;
      LONG       <= long_nxt;
    end else begin
      PRESS      <= 1'b0;
      RELEASE    <= 1'b0;
      LONG       <= 1'b0;
    end
  end

  // Next-state, counter and long-press flag logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    long_fired_nxt = long_fired;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_M1) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = CNT_W'(1);
        end else begin
          // Counter parks at the long threshold; long_fired prevents repeats.
          if (cnt != LONG_M1) cnt_nxt = cnt + CNT_W'(1);
          if (cnt == LONG_M1 && !long_fired) long_fired_nxt = 1'b1;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          // Glitch while held: return to HIGH but remember the long press.
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_M1) begin
          state_nxt      = IDLE_LOW;
          cnt_nxt        = '0;
          long_fired_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: pulses mark accepted transitions, level follows them.
  always_comb begin
    press_nxt   = (state == CHECK_HIGH) && s  && (cnt == STABLE_M1);
    release_nxt = (state == CHECK_LOW)  && !s && (cnt == STABLE_M1);
    long_nxt    = (state == HIGH) && s && (cnt == LONG_M1) && !long_fired;
    botout_nxt  = BOTOUT;
    if (press_nxt)   botout_nxt = 1'b1;
    if (release_nxt) botout_nxt = 1'b0;
  end

endmodule

// File: rtl/debounce_button_array.sv
// Array of independent push-button debouncers feeding the multiplier
// control FSM; one debounce_channel per button.
module debounce_button_array
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 10,
  parameter int LONG_CYCLES   = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  input  logic [N_CH-1:0] BOT,
  output logic [N_CH-1:0] BOTOUT,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] LONG
);

  // Reject illegal parameter sets while elaborating.
  if (!params_ok(N_CH, CNT_W, STABLE_CYCLES, LONG_CYCLES, SYNC_STAGES)) begin : g_param_err
    $error("debounce_button_array: illegal parameter set");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .CLK     (CLK),
      .RESET   (RESET),
      .EN      (EN),
      .BOT     (BOT[i]),
      .BOTOUT  (BOTOUT[i]),
      .PRESS   (PRESS[i]),
      .RELEASE (RELEASE[i]),
      .LONG    (LONG[i])
    );
  end

endmodule

// File: tb/tb_debounce_button_array.sv
// Directed bench for debounce_button_array: a vector table for reset, press
// and release, plus hand-written sequences for bounce, long press, glitch,
// enable freeze and mid-operation reset.
module tb_debounce_button_array;

  localparam int N_CH = 2;

  logic            CLK;
  logic            RESET;
  logic            EN;
  logic [N_CH-1:0] BOT;
  logic [N_CH-1:0] BOTOUT, PRESS, RELEASE, LONG;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] bot;
    logic [1:0] eb;
    logic [1:0] ep;
    logic [1:0] er;
    logic [1:0] el;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  debounce_button_array #(
    .N_CH          (N_CH),
    .CNT_W         (16),
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (20),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (EN),
    .BOT     (BOT),
    .BOTOUT  (BOTOUT),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .LONG    (LONG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic add(input logic rst, input logic en, input logic [1:0] bot,
                     input logic [1:0] eb, input logic [1:0] ep,
                     input logic [1:0] er, input logic [1:0] el);
    vec_t v;
    v.rst = rst; v.en = en; v.bot = bot;
    v.eb = eb; v.ep = ep; v.er = er; v.el = el;
    vecs.push_back(v);
  endtask

  // Drive one vector, clock one edge, compare all outputs 1 ns later.
  task automatic apply(input vec_t v, input string name);
    logic [7:0] got, want;
    RESET = v.rst;
    EN    = v.en;
    BOT   = v.bot;
    @(posedge CLK);
    #1;
    got  = {BOTOUT, PRESS, RELEASE, LONG};
    want = {v.eb, v.ep, v.er, v.el};
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec%0d: botout/press/release/long got=%b required=%b",
               name, n_vec, got, want);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic en,
                      input logic [1:0] bot, input logic [1:0] eb,
                      input logic [1:0] ep, input logic [1:0] er,
                      input logic [1:0] el);
    vec_t v;
    v.rst = rst; v.en = en; v.bot = bot;
    v.eb = eb; v.ep = ep; v.er = er; v.el = el;
    apply(v, name);
  endtask

  initial begin
    RESET = 1'b0;
    EN    = 1'b1;
    BOT   = 2'b00;

    // Reset held with both buttons high, then released: PRESS at edge 6.
    for (int i = 0; i < 3; i++) add(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    // Both released together: RELEASE at edge 6.
    for (int i = 0; i < 5; i++) add(1, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Clean press on channel 0 only.
    for (int i = 0; i < 5; i++) add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);

    foreach (vecs[k]) apply(vecs[k], "table");

    // Long press: press accepted at edge 6, LONG at edge 26, held to edge 45.
    for (int e = 8; e <= 45; e++)
      step("long_hold", 1, 1, 2'b01, 2'b01, 2'b00, 2'b00,
           (e == 26) ? 2'b01 : 2'b00);
    for (int e = 1; e <= 7; e++)
      step("long_release", 1, 1, 2'b00, (e < 6) ? 2'b01 : 2'b00, 2'b00,
           (e == 6) ? 2'b01 : 2'b00, 2'b00);

    // Bounce: 3 high / 1 low never reaches 4 stable samples.
    for (int i = 0; i < 40; i++)
      step("bounce", 1, 1, ((i % 4) != 3) ? 2'b01 : 2'b00,
           2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++)
      step("bounce_tail", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Release glitch after LONG: no RELEASE, no second LONG.
    for (int e = 1; e <= 30; e++)
      step("glitch_press", 1, 1, 2'b01, (e >= 6) ? 2'b01 : 2'b00,
           (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 26) ? 2'b01 : 2'b00);
    for (int e = 31; e <= 32; e++)
      step("glitch_drop", 1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int e = 33; e <= 62; e++)
      step("glitch_rehold", 1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int e = 1; e <= 7; e++)
      step("glitch_release", 1, 1, 2'b00, (e < 6) ? 2'b01 : 2'b00, 2'b00,
           (e == 6) ? 2'b01 : 2'b00, 2'b00);

    // EN low for 10 edges while in CHECK_HIGH: PRESS moves from edge 6 to 16.
    for (int e = 1; e <= 18; e++)
      step("en_freeze", 1, (e >= 4 && e <= 13) ? 1'b0 : 1'b1, 2'b01,
           (e >= 16) ? 2'b01 : 2'b00, (e == 16) ? 2'b01 : 2'b00,
           2'b00, 2'b00);

    // Reset while HIGH: level drops next cycle, no RELEASE afterwards.
    step("reset_high", 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++)
      step("after_reset", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
